// File: rtl/data_ram_bridge.sv
// Bridges a single-cycle MEM-stage load/store onto a handshaked, variable-latency data bus.
// state | meaning: IDLE wait for request | BUSY bus access in flight | DONE result valid, pipeline advances
module data_ram_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        stall_req_o,
  output logic        align_err_o,
  output logic        timeout_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;
  logic        aligned;

  assign aligned = (mem_addr_i[1:0] == 2'b00);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_ce_i && aligned) begin
          addr_d  = mem_addr_i;
          we_d    = mem_we_i;
          wdata_d = mem_wdata_i;
          req_d   = 1'b1;
          cnt_d   = 16'd0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus_ack_i) begin
          req_d   = 1'b0;
          if (!we_q) rdata_d = bus_rdata_i;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          rdata_d   = 32'h0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      // mem_ce_i here still belongs to the instruction that just completed
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= 16'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      timeout_q <= timeout_d;
    end
  end

  assign stall_req_o = ((state_q == IDLE) && mem_ce_i && aligned) || (state_q == BUSY);
  assign align_err_o = (state_q == IDLE) && mem_ce_i && !aligned;
  assign mem_rdata_o = rdata_q;
  assign timeout_o   = timeout_q;
  assign bus_req_o   = req_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_wdata_o = wdata_q;

endmodule

// File: tb/tb_data_ram_bridge.sv
// Randomized bench: a per-cycle expected-waveform schedule is planned from transaction rules, then replayed and compared.
module tb_data_ram_bridge;
  localparam int TO = 4;
  localparam int N  = 2048;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mem_ce_i = 1'b0, mem_we_i = 1'b0, bus_ack_i = 1'b0;
  logic [31:0] mem_addr_i = '0, mem_wdata_i = '0, bus_rdata_i = '0;
  logic [31:0] mem_rdata_o, bus_addr_o, bus_wdata_o;
  logic        stall_req_o, align_err_o, timeout_o, bus_req_o, bus_we_o;

  data_ram_bridge #(.TIMEOUT(TO)) dut (
    .clk(clk), .resetn(resetn),
    .mem_ce_i(mem_ce_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .stall_req_o(stall_req_o), .align_err_o(align_err_o),
    .timeout_o(timeout_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  // stimulus and expected outputs per cycle
  bit          i_ce[N], i_we[N], i_ack[N];
  logic [31:0] i_addr[N], i_wd[N], i_rd[N];
  bit          e_req[N], e_stall[N], e_aerr[N], e_to[N], e_we[N];
  logic [31:0] e_addr[N], e_wd[N], e_rd[N];
  bit          d_req[N], d_stall[N];
  logic [31:0] d_rd[N];
  bit          d_to[N], d_aerr[N];
  int          nc = 0;
  logic [31:0] cur_rd = 32'h0;
  int          checks = 0, errors = 0;

  task automatic chk(string name, int cyc, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic emit(bit ce, bit we, logic [31:0] addr, logic [31:0] wd, bit ack,
                      bit req, bit stall, bit aerr, bit to);
    if (nc >= N) $fatal(1, "FAIL schedule overflow cycle %0d", nc);
    i_ce[nc] = ce; i_we[nc] = we; i_addr[nc] = addr; i_wd[nc] = wd; i_ack[nc] = ack;
    i_rd[nc] = $urandom;
    e_req[nc] = req; e_stall[nc] = stall; e_aerr[nc] = aerr; e_to[nc] = to;
    e_we[nc] = we; e_addr[nc] = addr; e_wd[nc] = wd; e_rd[nc] = cur_rd;
    nc++;
  endtask

  function automatic logic [31:0] rnd_aligned();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  // An access waiting k cycles for ack; k >= TO means no ack and the watchdog fires.
  // The bus holds req for min(k, TO-1)+1 cycles, then one DONE cycle.
  task automatic access(bit we, logic [31:0] addr, logic [31:0] wd, int k, logic [31:0] rdv,
                        bit done_ce, logic [31:0] done_addr);
    bit tout;
    int n;
    tout = (k >= TO);
    n = tout ? TO - 1 : k;
    emit(1'b1, we, addr, wd, 1'($urandom_range(0, 1)), 1'b0, 1'b1, 1'b0, 1'b0);
    for (int j = 0; j <= n; j++) begin
      emit(1'b1, we, addr, wd, (!tout && j == k), 1'b1, 1'b1, 1'b0, 1'b0);
      if (!tout && j == k) i_rd[nc-1] = rdv;
    end
    if (tout) cur_rd = 32'h0;
    else if (!we) cur_rd = rdv;
    emit(done_ce, 1'($urandom_range(0, 1)), done_addr, $urandom, 1'($urandom_range(0, 1)),
         1'b0, 1'b0, 1'b0, tout);
  endtask

  task automatic gap(int g);
    for (int j = 0; j < g; j++)
      emit(1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)),
           1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic misaligned(logic [31:0] addr);
    emit(1'b1, 1'($urandom_range(0, 1)), addr, $urandom, 1'($urandom_range(0, 1)),
         1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  function automatic int count_stall(int s, int len);
    int cnt = 0;
    for (int c = s; c < s + len; c++) cnt += int'(d_stall[c]);
    return cnt;
  endfunction

  function automatic int count_req(int s, int len);
    int cnt = 0;
    for (int c = s; c < s + len; c++) cnt += int'(d_req[c]);
    return cnt;
  endfunction

  int t_lw, t_sw, t_mis, t_to, t_b2b;
  logic [31:0] rd_before_sw;

  initial begin
    logic [31:0] a;
    int k;
    // directed scenarios
    gap(1);
    t_lw = nc; access(1'b0, 32'h10, 32'h0, 0, 32'h12345678, 1'b0, 32'h0);
    gap(2);
    t_sw = nc; access(1'b1, 32'h20, 32'hCAFEF00D, 3, 32'hDEADBEEF, 1'b0, 32'h0);
    gap(1);
    t_mis = nc; misaligned(32'h13);
    gap(1);
    t_to = nc; access(1'b0, 32'h40, 32'h0, TO + 2, 32'h0, 1'b0, 32'h0);
    gap(1);
    t_b2b = nc;
    access(1'b0, 32'h50, 32'h0, 1, 32'hA5A5A5A5, 1'b1, 32'h50);
    access(1'b0, 32'h54, 32'h0, 0, 32'h5A5A5A5A, 1'b1, 32'h54);
    gap(1);
    // random traffic
    for (int t = 0; t < 120; t++) begin
      case ($urandom_range(0, 4))
        0: begin
          a = $urandom;
          a[1:0] = 2'($urandom_range(1, 3));
          misaligned(a);
        end
        1: gap($urandom_range(1, 3));
        default: begin
          k = $urandom_range(0, TO + 1);
          a = $urandom;
          access(1'($urandom_range(0, 1)), rnd_aligned(), $urandom, k, $urandom,
                 1'($urandom_range(0, 1)), a);
        end
      endcase
    end
    gap(2);

    #12;
    chk("rst_req", -1, 32'(bus_req_o), 32'h0);
    chk("rst_rdata", -1, mem_rdata_o, 32'h0);
    chk("rst_addr", -1, bus_addr_o, 32'h0);
    chk("rst_wdata", -1, bus_wdata_o, 32'h0);
    chk("rst_we", -1, 32'(bus_we_o), 32'h0);
    chk("rst_timeout", -1, 32'(timeout_o), 32'h0);
    chk("rst_stall", -1, 32'(stall_req_o), 32'h0);
    @(negedge clk);
    resetn = 1'b1;

    for (int c = 0; c < nc; c++) begin
      @(posedge clk); #1;
      mem_ce_i = i_ce[c]; mem_we_i = i_we[c]; mem_addr_i = i_addr[c]; mem_wdata_i = i_wd[c];
      bus_ack_i = i_ack[c]; bus_rdata_i = i_rd[c];
      @(negedge clk);
      d_req[c] = bus_req_o; d_stall[c] = stall_req_o; d_rd[c] = mem_rdata_o;
      d_to[c] = timeout_o; d_aerr[c] = align_err_o;
      chk("stall", c, 32'(stall_req_o), 32'(e_stall[c]));
      chk("align_err", c, 32'(align_err_o), 32'(e_aerr[c]));
      chk("bus_req", c, 32'(bus_req_o), 32'(e_req[c]));
      chk("timeout", c, 32'(timeout_o), 32'(e_to[c]));
      chk("mem_rdata", c, mem_rdata_o, e_rd[c]);
      if (e_req[c]) begin
        chk("bus_we", c, 32'(bus_we_o), 32'(e_we[c]));
        chk("bus_addr", c, bus_addr_o, e_addr[c]);
        chk("bus_wdata", c, bus_wdata_o, e_wd[c]);
      end
    end

    // hand-computed pins of the directed scenarios
    chk("lw_stall_cycles", t_lw, count_stall(t_lw, 3), 2);
    chk("lw_req_cycles", t_lw, count_req(t_lw, 3), 1);
    chk("lw_rdata", t_lw + 2, d_rd[t_lw + 2], 32'h12345678);
    rd_before_sw = d_rd[t_sw];
    chk("sw_stall_cycles", t_sw, count_stall(t_sw, 6), 5);
    chk("sw_req_cycles", t_sw, count_req(t_sw, 6), 4);
    chk("sw_rdata_kept", t_sw + 5, d_rd[t_sw + 5], 32'h12345678);
    chk("sw_rdata_pre", t_sw, rd_before_sw, 32'h12345678);
    chk("mis_align_err", t_mis, 32'(d_aerr[t_mis]), 32'h1);
    chk("mis_stall", t_mis, 32'(d_stall[t_mis]), 32'h0);
    chk("to_req_cycles", t_to, count_req(t_to, 6), TO);
    chk("to_pulse", t_to + 5, 32'(d_to[t_to + 5]), 32'h1);
    chk("to_pulse_len", t_to, 32'(d_to[t_to + 4]) + 32'(d_to[t_to + 6]), 32'h0);
    chk("to_rdata", t_to + 5, d_rd[t_to + 5], 32'h0);
    chk("b2b_req_cycles", t_b2b, count_req(t_b2b, 8), 3);
    chk("b2b_second_req", t_b2b + 5, 32'(d_req[t_b2b + 5]), 32'h1);
    chk("b2b_second_rdata", t_b2b + 6, d_rd[t_b2b + 6], 32'h5A5A5A5A);

    // async reset while BUSY, then a late ack
    @(posedge clk); #1;
    mem_ce_i = 1'b1; mem_we_i = 1'b1; mem_addr_i = 32'h60; mem_wdata_i = 32'h11112222; bus_ack_i = 1'b0;
    @(posedge clk); #1;
    mem_ce_i = 1'b0;
    @(negedge clk);
    chk("ar_req_before", 0, 32'(bus_req_o), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("ar_req", 0, 32'(bus_req_o), 32'h0);
    chk("ar_stall", 0, 32'(stall_req_o), 32'h0);
    chk("ar_addr", 0, bus_addr_o, 32'h0);
    chk("ar_wdata", 0, bus_wdata_o, 32'h0);
    chk("ar_we", 0, 32'(bus_we_o), 32'h0);
    chk("ar_rdata", 0, mem_rdata_o, 32'h0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'hFFFFFFFF;
    @(negedge clk);
    chk("late_ack_req", 1, 32'(bus_req_o), 32'h0);
    chk("late_ack_stall", 1, 32'(stall_req_o), 32'h0);
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack_rdata", 2, mem_rdata_o, 32'h0);
    chk("late_ack_timeout", 2, 32'(timeout_o), 32'h0);
    chk("late_ack_req2", 2, 32'(bus_req_o), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
